// File: rtl/ats21_cmd_decoder.sv
// Two-beat command capture and mode/range gating in front of the ATS21 alarm/timer core.
// Legal commands go out over a valid/ready handshake; rejected ones raise a one-cycle error pulse.
package ats21_cmd_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HI,
      ST_LO,
      ST_HOLD
   } state_t;

   typedef struct packed {
      logic [2:0]  op;
      logic [3:0]  clk_num;
      logic [4:0]  idx;
      logic        flag;
      logic [1:0]  rate;
      logic [15:0] value;
   } cmd_t;

   typedef struct packed {
      logic       active;
      logic [1:0] allow_tmr;
      logic [1:0] allow_clk;
   } mode_t;

   localparam logic [2:0] OP_NOP     = 3'b000;
   localparam logic [2:0] OP_CLK_SET = 3'b001;
   localparam logic [2:0] OP_CLK_EN  = 3'b010;
   localparam logic [2:0] OP_MODE    = 3'b011;
   localparam logic [2:0] OP_ILLEGAL = 3'b100;
   localparam logic [2:0] OP_ALARM   = 3'b101;
   localparam logic [2:0] OP_TIMER   = 3'b110;
   localparam logic [2:0] OP_TMR_EN  = 3'b111;

   localparam logic [1:0] ERR_ILLEGAL = 2'b01;
   localparam logic [1:0] ERR_LOCKED  = 2'b10;
   localparam logic [1:0] ERR_RANGE   = 2'b11;

   localparam mode_t MODE_RESET = '{active: 1'b1, allow_tmr: 2'b11, allow_clk: 2'b11};

endpackage

module ats21_cmd_decoder
   import ats21_cmd_decoder_pkg::*;
#(
   parameter int unsigned NUM_CLOCKS = 16,
   parameter int unsigned NUM_TIMERS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [15:0] ctrl,
   output logic        ready,
   output logic        cmd_valid,
   input  logic        cmd_ready,
   output logic [2:0]  cmd_op,
   output logic [3:0]  cmd_clk,
   output logic [4:0]  cmd_idx,
   output logic        cmd_flag,
   output logic [1:0]  cmd_rate,
   output logic [15:0] cmd_value,
   output logic        err_valid,
   output logic [1:0]  err_code,
   output logic        mode_active,
   output logic        overrun
);

   localparam int unsigned BEAT_W = 16;

   state_t            state_q, state_d;
   logic [BEAT_W-1:0] hi_q, hi_d;
   cmd_t              cmd_q, cmd_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              err_valid_q, err_valid_d;
   logic [1:0]        err_code_q, err_code_d;
   mode_t             mode_q, mode_d;
   logic              overrun_q, overrun_d;
   logic              ready_q, ready_d;

   cmd_t              fld;
   logic [2:0]        op;
   logic              uses_clk, uses_idx, locked, out_of_range;
   logic              unused_hi_bits;

   assign op             = hi_q[15:13];
   assign unused_hi_bits = ^hi_q[5:4];

   // Field extraction and gating checks for the instruction sitting in hi_q plus the live lo beat
   always_comb begin
      fld          = '0;
      uses_clk     = 1'b0;
      uses_idx     = 1'b0;
      locked       = 1'b0;
      out_of_range = 1'b0;
      fld.op       = op;
      case (op)
         OP_CLK_SET: begin
            fld.clk_num = hi_q[12:9];
            fld.rate    = hi_q[7:6];
            uses_clk    = 1'b1;
            locked      = ~mode_q.allow_clk[1];
         end
         OP_CLK_EN: begin
            fld.clk_num = hi_q[12:9];
            fld.flag    = hi_q[7];
            uses_clk    = 1'b1;
            locked      = ~mode_q.allow_clk[0];
         end
         OP_ALARM, OP_TIMER: begin
            fld.clk_num = hi_q[3:0];
            fld.idx     = hi_q[12:8];
            fld.flag    = (op == OP_ALARM) ? hi_q[7] : 1'b0;
            fld.value   = ctrl;
            uses_clk    = 1'b1;
            uses_idx    = 1'b1;
            locked      = ~mode_q.allow_tmr[1];
         end
         OP_TMR_EN: begin
            fld.idx     = hi_q[12:8];
            fld.flag    = hi_q[7];
            uses_idx    = 1'b1;
            locked      = ~mode_q.allow_tmr[0];
         end
         default: ;
      endcase
      out_of_range = (uses_clk && (32'(fld.clk_num) >= NUM_CLOCKS)) ||
                     (uses_idx && (32'(fld.idx) >= NUM_TIMERS));
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d     = state_q;
      hi_d        = hi_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      mode_d      = mode_q;
      overrun_d   = overrun_q | (req && (state_q != ST_IDLE));

      case (state_q)
         ST_IDLE: begin
            if (req) state_d = ST_HI;
         end
         ST_HI: begin
            hi_d    = ctrl;
            state_d = ST_LO;
         end
         ST_LO: begin
            state_d = ST_IDLE;
            if (op == OP_NOP) begin
               state_d = ST_IDLE;
            end else if (op == OP_ILLEGAL) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_ILLEGAL;
            end else if (op == OP_MODE) begin
               mode_d = '{active: hi_q[12], allow_tmr: hi_q[11:10], allow_clk: hi_q[9:8]};
            end else if (!mode_q.active || locked) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_LOCKED;
            end else if (out_of_range) begin
               err_valid_d = 1'b1;
               err_code_d  = ERR_RANGE;
            end else begin
               cmd_d       = fld;
               cmd_valid_d = 1'b1;
               state_d     = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (cmd_ready) begin
               cmd_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         hi_q        <= '0;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= '0;
         mode_q      <= MODE_RESET;
         overrun_q   <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         state_q     <= state_d;
         hi_q        <= hi_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         mode_q      <= mode_d;
         overrun_q   <= overrun_d;
         ready_q     <= ready_d;
      end
   end

   assign ready       = ready_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_op      = cmd_q.op;
   assign cmd_clk     = cmd_q.clk_num;
   assign cmd_idx     = cmd_q.idx;
   assign cmd_flag    = cmd_q.flag;
   assign cmd_rate    = cmd_q.rate;
   assign cmd_value   = cmd_q.value;
   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;
   assign mode_active = mode_q.active;
   assign overrun     = overrun_q;

endmodule

// File: tb/tb_ats21_cmd_decoder.sv
// Directed bench for ats21_cmd_decoder: hand-decoded instruction vectors with fixed expected fields.
// The DUT is built with 8 clocks and 20 timers so both range limits can be hit.
module tb_ats21_cmd_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req;
   logic [15:0] ctrl;
   logic        cmd_ready;
   logic        ready, cmd_valid, cmd_flag, err_valid, mode_active, overrun;
   logic [2:0]  cmd_op;
   logic [3:0]  cmd_clk;
   logic [4:0]  cmd_idx;
   logic [1:0]  cmd_rate, err_code;
   logic [15:0] cmd_value;

   int unsigned vec_cnt = 0;
   int unsigned miscompare_cnt = 0;

   ats21_cmd_decoder #(.NUM_CLOCKS(8), .NUM_TIMERS(20)) dut (
      .clk(clk), .reset(reset), .req(req), .ctrl(ctrl), .ready(ready),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_clk(cmd_clk),
      .cmd_idx(cmd_idx), .cmd_flag(cmd_flag), .cmd_rate(cmd_rate), .cmd_value(cmd_value),
      .err_valid(err_valid), .err_code(err_code), .mode_active(mode_active), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         miscompare_cnt++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Runs req / hi / lo from IDLE; returns at the negedge just after the decode edge.
   task automatic issue(input logic [15:0] hi, input logic [15:0] lo);
      @(negedge clk); req = 1'b1;
      @(negedge clk); req = 1'b0; ctrl = hi;
      @(negedge clk); ctrl = lo;
      @(negedge clk); ctrl = 16'hDEAD;
   endtask

   task automatic check_cmd(input string tag, input logic [2:0] op, input logic [3:0] ck,
                            input logic [4:0] idx, input logic fl, input logic [1:0] rt,
                            input logic [15:0] val);
      check({tag, ".valid"}, cmd_valid, 1);
      check({tag, ".err"},   err_valid, 0);
      check({tag, ".ready"}, ready, 0);
      check({tag, ".op"},    cmd_op, op);
      check({tag, ".clk"},   cmd_clk, ck);
      check({tag, ".idx"},   cmd_idx, idx);
      check({tag, ".flag"},  cmd_flag, fl);
      check({tag, ".rate"},  cmd_rate, rt);
      check({tag, ".value"}, cmd_value, val);
   endtask

   task automatic check_err(input string tag, input logic [1:0] code);
      check({tag, ".err_valid"}, err_valid, 1);
      check({tag, ".err_code"},  err_code, code);
      check({tag, ".cmd_valid"}, cmd_valid, 0);
      check({tag, ".ready"},     ready, 1);
      @(negedge clk);
      check({tag, ".pulse_end"}, err_valid, 0);
      check({tag, ".code_held"}, err_code, code);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".cmd_valid"}, cmd_valid, 0);
      check({tag, ".err_valid"}, err_valid, 0);
      check({tag, ".ready"},     ready, 1);
   endtask

   task automatic accept(input string tag);
      cmd_ready = 1'b1;
      @(negedge clk); cmd_ready = 1'b0;
      check({tag, ".acc_valid"}, cmd_valid, 0);
      check({tag, ".acc_ready"}, ready, 1);
   endtask

   initial begin
      reset = 1'b0; req = 1'b0; ctrl = '0; cmd_ready = 1'b0;
      #12;
      check("rst.ready", ready, 1);
      check("rst.cmd_valid", cmd_valid, 0);
      check("rst.err_valid", err_valid, 0);
      check("rst.err_code", err_code, 0);
      check("rst.overrun", overrun, 0);
      check("rst.mode_active", mode_active, 1);
      check("rst.cmd_fields", {cmd_op, cmd_clk, cmd_idx, cmd_flag, cmd_rate, cmd_value}, 0);
      @(negedge clk); reset = 1'b1;

      // Alarm set with backpressure
      issue(16'hA283, 16'h1234);
      check_cmd("alarm", 3'b101, 4'd3, 5'd2, 1'b1, 2'd0, 16'h1234);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_cmd("alarm_hold", 3'b101, 4'd3, 5'd2, 1'b1, 2'd0, 16'h1234);
      end
      accept("alarm");

      // Timer interval, then a req while holding it
      issue(16'hC507, 16'hABCD);
      check_cmd("timer", 3'b110, 4'd7, 5'd5, 1'b0, 2'd0, 16'hABCD);
      req = 1'b1;
      @(negedge clk); req = 1'b0; ctrl = 16'hFFFF;
      @(negedge clk);
      check("hold_req.overrun", overrun, 1);
      check_cmd("hold_req", 3'b110, 4'd7, 5'd5, 1'b0, 2'd0, 16'hABCD);
      accept("timer");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_quiet("no_recapture");
      end
      check("overrun_sticky", overrun, 1);

      // Inactive mode rejects everything except illegal-op priority
      issue(16'h6000, 16'h0000);
      check("mode_off.active", mode_active, 0);
      check_quiet("mode_off");
      issue(16'h2400, 16'h0000);
      check_err("inactive", 2'b10);
      issue(16'h8000, 16'h0000);
      check_err("illegal_inactive", 2'b01);
      issue(16'h7F00, 16'h0000);
      check("mode_on.active", mode_active, 1);
      check_quiet("mode_on");

      // Clock lock bits
      issue(16'h7D00, 16'h0000);
      issue(16'h24C0, 16'h0000);
      check_err("clk_set_locked", 2'b10);
      issue(16'h4480, 16'h0000);
      check_cmd("clk_en", 3'b010, 4'd2, 5'd0, 1'b1, 2'd0, 16'h0000);
      accept("clk_en");

      // Timer lock bits
      issue(16'h7700, 16'h0000);
      issue(16'hA283, 16'h1234);
      check_err("alarm_locked", 2'b10);
      issue(16'hF380, 16'hFFFF);
      check_cmd("tmr_en_19", 3'b111, 4'd0, 5'd19, 1'b1, 2'd0, 16'h0000);
      accept("tmr_en_19");

      issue(16'h7F00, 16'h0000);
      issue(16'h24C0, 16'h5555);
      check_cmd("clk_set", 3'b001, 4'd2, 5'd0, 1'b0, 2'd3, 16'h0000);
      accept("clk_set");

      // Range boundaries
      issue(16'h5280, 16'h0000);
      check_err("clk9_range", 2'b11);
      issue(16'h4E00, 16'h0000);
      check_cmd("clk7_ok", 3'b010, 4'd7, 5'd0, 1'b0, 2'd0, 16'h0000);
      accept("clk7_ok");
      issue(16'hA108, 16'h0001);
      check_err("alarm_clk8_range", 2'b11);
      issue(16'hF480, 16'h0000);
      check_err("tmr20_range", 2'b11);

      // Illegal opcode and NOP
      issue(16'h8000, 16'h0000);
      check_err("illegal", 2'b01);
      issue(16'h0000, 16'hFFFF);
      check_quiet("nop");
      check("nop.err_code_kept", err_code, 2'b01);

      // Reset while in LO with overrun set and mode inactive
      issue(16'h6000, 16'h0000);
      @(negedge clk); req = 1'b1;
      @(negedge clk); ctrl = 16'hA283;
      @(negedge clk); req = 1'b0; ctrl = 16'h1234;
      check("pre_rst.overrun", overrun, 1);
      check("pre_rst.ready", ready, 0);
      reset = 1'b0;
      #1;
      check("mid_rst.ready", ready, 1);
      check("mid_rst.cmd_valid", cmd_valid, 0);
      check("mid_rst.overrun", overrun, 0);
      check("mid_rst.mode_active", mode_active, 1);
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_quiet("post_rst");
      end
      issue(16'hA283, 16'h4321);
      check_cmd("post_rst_alarm", 3'b101, 4'd3, 5'd2, 1'b1, 2'd0, 16'h4321);
      accept("post_rst_alarm");

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
      $finish;
   end

endmodule
